// File: rtl/fare_pkg.sv
// Shared types and coin decoding for the fare collector.
package fare_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_PASS = 2'd2,
        ST_CHANGE    = 2'd3
    } state_e;

    localparam logic [1:0] COIN_5  = 2'd0;
    localparam logic [1:0] COIN_10 = 2'd1;
    localparam logic [1:0] COIN_25 = 2'd2;
    localparam logic [1:0] COIN_50 = 2'd3;

    function automatic logic [7:0] coin_cents(input logic [1:0] code);
        logic [7:0] cents;
        case (code)
            COIN_5:  cents = 8'd5;
            COIN_10: cents = 8'd10;
            COIN_25: cents = 8'd25;
            default: cents = 8'd50;
        endcase
        return cents;
    endfunction

endpackage

// File: rtl/fare_collector.sv
// Coin-side controller: accumulates credit, grants one turnstile passage, returns change.
// state      | meaning
// IDLE       | accepting coins, grant when credit >= FARE, cancel refunds
// GRANT      | coin grant high for this single cycle
// WAIT_PASS  | waiting for passage or timeout
// CHANGE     | one change_pulse per CHANGE_UNIT until credit is zero
module fare_collector
    import fare_pkg::*;
#(
    parameter int FARE           = 100,
    parameter int CHANGE_UNIT    = 5,
    parameter int CREDIT_W       = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_value,
    input  logic                cancel,
    input  logic                pass,
    output logic                coin,
    output logic                change_pulse,
    output logic                coin_ack,
    output logic                coin_reject,
    output logic                timeout,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    if ((FARE % CHANGE_UNIT) != 0 || FARE < 5 || (FARE - 5 + 50) >= (2 ** CREDIT_W)) begin : g_param_err
        $error("fare_collector: FARE must be a multiple of CHANGE_UNIT, >= 5, and FARE+45 must fit CREDIT_W");
    end

    localparam logic [CREDIT_W-1:0] FARE_C   = CREDIT_W'(FARE);
    localparam logic [CREDIT_W-1:0] UNIT_C   = CREDIT_W'(CHANGE_UNIT);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  coin_q, coin_d;
    logic                  pulse_q, pulse_d;
    logic                  ack_q, ack_d;
    logic                  rej_q, rej_d;
    logic                  tmo_pulse_q, tmo_pulse_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            credit_q    <= '0;
            tmo_q       <= '0;
            coin_q      <= 1'b0;
            pulse_q     <= 1'b0;
            ack_q       <= 1'b0;
            rej_q       <= 1'b0;
            tmo_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            tmo_q       <= tmo_d;
            coin_q      <= coin_d;
            pulse_q     <= pulse_d;
            ack_q       <= ack_d;
            rej_q       <= rej_d;
            tmo_pulse_q <= tmo_pulse_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        tmo_d       = tmo_q;
        coin_d      = 1'b0;
        pulse_d     = 1'b0;
        ack_d       = 1'b0;
        rej_d       = 1'b0;
        tmo_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Cancel beats both a simultaneous coin and a pending grant.
                if (cancel) begin
                    rej_d = coin_valid;
                    if (credit_q != '0) begin
                        state_d = ST_CHANGE;
                    end
                end else if (credit_q >= FARE_C) begin
                    state_d  = ST_GRANT;
                    credit_d = credit_q - FARE_C;
                    coin_d   = 1'b1;
                    rej_d    = coin_valid;
                end else if (coin_valid) begin
                    credit_d = credit_q + CREDIT_W'(coin_cents(coin_value));
                    ack_d    = 1'b1;
                end
            end

            ST_GRANT: begin
                rej_d   = coin_valid;
                tmo_d   = '0;
                state_d = ST_WAIT_PASS;
            end

            ST_WAIT_PASS: begin
                rej_d = coin_valid;
                tmo_d = tmo_q + 1'b1;
                if (pass || tmo_q >= TMO_LAST) begin
                    tmo_pulse_d = !pass;
                    state_d     = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end

            ST_CHANGE: begin
                rej_d = coin_valid;
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (credit_q <= UNIT_C) begin
                    pulse_d  = 1'b1;
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    pulse_d  = 1'b1;
                    credit_d = credit_q - UNIT_C;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign coin         = coin_q;
    assign change_pulse = pulse_q;
    assign coin_ack     = ack_q;
    assign coin_reject  = rej_q;
    assign timeout      = tmo_pulse_q;
    assign busy         = busy_q;
    assign credit       = credit_q;

endmodule

// File: tb/tb_fare_collector.sv
// Scoreboard bench for fare_collector: expected events queued at stimulus, matched at output.
module tb_fare_collector;

    localparam int FARE = 100;
    localparam int UNIT = 5;
    localparam int TMO  = 16;
    localparam int CW   = 8;

    localparam int EV_ACK   = 0;
    localparam int EV_REJ   = 1;
    localparam int EV_GRANT = 2;
    localparam int EV_TMO   = 3;
    localparam int EV_END   = 4;

    logic          clk;
    logic          rst;
    logic          coin_valid;
    logic [1:0]    coin_value;
    logic          cancel;
    logic          pass;
    logic          coin;
    logic          change_pulse;
    logic          coin_ack;
    logic          coin_reject;
    logic          timeout;
    logic          busy;
    logic [CW-1:0] credit;

    fare_collector #(
        .FARE(FARE), .CHANGE_UNIT(UNIT), .CREDIT_W(CW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .cancel(cancel), .pass(pass), .coin(coin), .change_pulse(change_pulse),
        .coin_ack(coin_ack), .coin_reject(coin_reject), .timeout(timeout),
        .busy(busy), .credit(credit)
    );

    typedef struct {
        int kind;
        int val;
        int aux;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  m_credit = 0;
    int  cents_tbl[4] = '{5, 10, 25, 50};

    int  pulse_cnt   = 0;
    int  since_grant = -1;
    logic prev_busy  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic string ev_name(input int kind);
        case (kind)
            EV_ACK:   return "ack";
            EV_REJ:   return "rej";
            EV_GRANT: return "grant";
            EV_TMO:   return "tmo";
            default:  return "end";
        endcase
    endfunction

    task automatic push(input int kind, input int val, input int aux);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.aux  = aux;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input int val, input int aux);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({"unexpected_", ev_name(kind)}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check({ev_name(e.kind), "_val"}, val, e.val);
            if (e.kind == EV_END) check("end_credit", aux, e.aux);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pulse_cnt   = 0;
            since_grant = -1;
            prev_busy   = 1'b0;
        end else begin
            if (coin_ack || coin_reject) check("ack_rej_excl", int'(coin_ack && coin_reject), 0);
            if (coin_ack) got(EV_ACK, int'(credit), 0);
            if (coin_reject) got(EV_REJ, int'(credit), 0);
            if (since_grant >= 0) since_grant++;
            if (coin) begin
                got(EV_GRANT, int'(credit), 0);
                since_grant = 0;
            end
            if (timeout) got(EV_TMO, since_grant, 0);
            if (change_pulse) pulse_cnt++;
            if (prev_busy && !busy) begin
                got(EV_END, pulse_cnt, int'(credit));
                pulse_cnt   = 0;
                since_grant = -1;
            end
            prev_busy = busy;
        end
    end

    task automatic drive(input logic [1:0] code, input logic v, input logic c, input logic p);
        @(posedge clk);
        #1;
        coin_value = code;
        coin_valid = v;
        cancel     = c;
        pass       = p;
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        cancel     = 1'b0;
        pass       = 1'b0;
    endtask

    task automatic coin_ok(input logic [1:0] code);
        m_credit += cents_tbl[code];
        push(EV_ACK, m_credit, 0);
        if (m_credit >= FARE) begin
            m_credit -= FARE;
            push(EV_GRANT, m_credit, 0);
        end
        drive(code, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic expect_refund();
        if (m_credit > 0) push(EV_END, m_credit / UNIT, 0);
        m_credit = 0;
    endtask

    task automatic finish_pass();
        push(EV_END, m_credit / UNIT, 0);
        m_credit = 0;
        drive(2'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_grant();
        int found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (coin) begin
                found = 1;
                break;
            end
        end
        check("grant_wait", found, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", exp_q.size(), 0);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_credit", int'(credit), m_credit);
    endtask

    initial begin
        int seen;
        rst        = 1'b0;
        coin_valid = 1'b0;
        coin_value = 2'd0;
        cancel     = 1'b0;
        pass       = 1'b0;

        // asynchronous reset observed before any clock edge
        #3 rst = 1'b1;
        #1;
        check("rst_outs", int'({coin, change_pulse, coin_ack, coin_reject, timeout, busy}), 0);
        check("rst_credit", int'(credit), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // 50+50: exact fare, grant, pass, no change
        coin_ok(2'd3);
        coin_ok(2'd3);
        wait_grant();
        finish_pass();
        drain();

        // 50+25+50: grant leaves 25, five change pulses
        coin_ok(2'd3);
        coin_ok(2'd2);
        coin_ok(2'd3);
        wait_grant();
        finish_pass();
        drain();

        // 25 then cancel refunds
        coin_ok(2'd2);
        expect_refund();
        drive(2'd0, 1'b0, 1'b1, 1'b0);
        drain();

        // coin and cancel together: cancel wins, then refund 25
        coin_ok(2'd2);
        push(EV_REJ, m_credit, 0);
        expect_refund();
        drive(2'd1, 1'b1, 1'b1, 1'b0);
        drain();

        // coin during WAIT_PASS rejected; pass while idle ignored
        coin_ok(2'd3);
        coin_ok(2'd3);
        wait_grant();
        push(EV_REJ, m_credit, 0);
        drive(2'd1, 1'b1, 1'b0, 1'b0);
        finish_pass();
        drain();
        drive(2'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("idle_pass_busy", int'(busy), 0);
        check("idle_pass_credit", int'(credit), 0);
        coin_ok(2'd1);
        drain();

        // timeout with 10 leftover: pulse 17 cycles after grant, then 2 change pulses
        coin_ok(2'd3);
        coin_ok(2'd3);
        push(EV_TMO, TMO + 1, 0);
        expect_refund();
        wait_grant();
        drain();

        // pass on the final WAIT_PASS cycle suppresses the timeout
        coin_ok(2'd3);
        coin_ok(2'd3);
        wait_grant();
        push(EV_END, 0, 0);
        repeat (TMO) @(posedge clk);
        #1 pass = 1'b1;
        @(posedge clk);
        #1 pass = 1'b0;
        drain();

        // reset in the middle of CHANGE discards the rest
        coin_ok(2'd3);
        coin_ok(2'd2);
        coin_ok(2'd3);
        wait_grant();
        drive(2'd0, 1'b0, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            @(negedge clk);
            if (change_pulse) seen++;
        end
        check("pulses_before_rst", seen, 2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_outs", int'({coin, change_pulse, coin_ack, coin_reject, timeout, busy}), 0);
        check("mid_rst_credit", int'(credit), 0);
        m_credit = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (change_pulse || busy) seen++;
        end
        check("post_rst_quiet", seen, 0);
        check("post_rst_credit", int'(credit), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
